score_seg_driver: RTL and testbench
===================================

// Module: score_seg_driver
// PURPOSE
//  Downstream consumer of the 4-digit anode scanner (active-low one-hot
//  enables, order 0111->1011->1101->1110). Converts a binary game score to
//  four BCD digits with a sequential double-dabble engine, holds them, and
//  drives the shared active-low segment bus for whichever digit the scanner
//  currently enables. Sits between the score counter and the board's 7-seg pins.
// PARAMETERS
//  LZB      1    1 = leading-zero blanking on thousands/hundreds/tens; 0 = show all zeros
//  MAX_VAL  9999 saturation ceiling for score_bin (decimal)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous active-high reset
//  score_bin   in   14  binary score, sampled on an accepted load
//  score_load  in   1   1-cycle request to convert score_bin
//  anodes      in   4   scanner enables, active-low (0111=thousands ... 1110=units)
//  seg         out  7   {g,f,e,d,c,b,a}, active-low
//  dp          out  1   decimal point, active-low; constant 1 (off)
//  busy        out  1   conversion in progress
//  ovf         out  1   last started conversion was saturated
// BEHAVIOUR
//  Reset: seg=7'h7F, dp=1, busy=0, ovf=0, digits=0000, pending cleared, FSM=IDLE.
//   Reset mid-conversion aborts it; digit registers are cleared, not committed.
//  FSM: IDLE, CONV.
//   IDLE & (score_load | pend_v) at edge E0: operand = min(value, MAX_VAL);
//     ovf <= (value > MAX_VAL); shift reg = {16'b0, operand}; cnt=0; ->CONV; busy=1.
//     Pending takes priority over a simultaneous new load; that load becomes pending.
//   CONV: each edge E1..E14 does add-3 (any BCD nibble >=5) then shift-left-1.
//     At E14: digits <= BCD result; busy=0; ->IDLE. Latency: load edge to
//     new digits = 14 cycles.
//  Load while busy (incl. at E14): score_bin captured in pend_reg, pend_v=1;
//   last load wins. Pending starts at the first IDLE edge; pend_v cleared there.
//  Digits update atomically; display never shows a partially converted value.
//  Segment path: seg registered; 1-cycle latency from anodes change.
//   anodes 0111->d3, 1011->d2, 1101->d1, 1110->d0; any other pattern
//   (0 or >1 low) -> seg=7'h7F.
//  Glyphs: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, active-low).
//  LZB=1: d3 blank if d3==0; d2 blank if d3==d2==0; d1 blank if d3==d2==d1==0;
//   d0 never blanked (score 0 shows "   0").
//  Widths: score_bin 14b (max 16383); BCD field 16b; cnt 4b, terminal 13 (0-based).
// STRUCTURE
//  seg7_pkg: glyph constants SEG_0..SEG_9, SEG_BLANK=7'h7F, anode codes
//   AN_D3..AN_D0, FSM state typedef, DD_SHIFTS=14.
//  One sub-module: seg7_decode (combinational 4-bit BCD + blank -> 7-bit
//   active-low segments); the top holds FSM, double-dabble, pending, seg reg.
// TESTING
//  1 rst for 2 cycles -> seg=7F, busy=0, ovf=0; drive anodes 1110 -> seg=40.
//  2 load 1234 -> busy 1 for 14 cycles; then anodes 0111/1011/1101/1110 ->
//    seg 79/24/30/19, each 1 cycle after the anode change.
//  3 load 12000 -> digits 9999, ovf=1; then load 5 -> ovf=0; LZB=1 ->
//    only the 1110 slot shows 12, others 7F.
//  4 load 42 at E0, load 77 at E3, load 88 at E9 -> 42 shown, then 88
//    converted (77 dropped); no 3rd conversion.
//  5 load 9999 then rst at E7 -> digits 0000, busy 0, pending clear.
//  6 anodes 1111, 0011, 0000 -> seg=7F; dp=1 at all times.

Source files
------------

// File: rtl/score_seg_driver_pkg.sv
// Shared constants for the score display: glyphs, anode codes, FSM encoding.
package score_seg_driver_pkg;

    // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scanner enables, active-low one-hot
    localparam logic [3:0] AN_D3 = 4'b0111;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D0 = 4'b1110;

    // Double-dabble geometry: 14 binary bits feed a 16-bit BCD field
    localparam int DD_SHIFTS = 14;
    localparam int BIN_W     = 14;
    localparam int BCD_W     = 16;

    // FSM encoding kept as plain constants for legacy tools
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_CONV = 1'b1;

endpackage

// File: rtl/score_seg_driver_decode.sv
// Combinational BCD digit to active-low 7-segment glyph, with blank override.
module seg7_decode
    import score_seg_driver_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; non-decimal codes and blanked digits go dark
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_seg_driver.sv
// Binary score -> BCD (sequential double-dabble) -> multiplexed 7-seg drive.
module score_seg_driver
    import score_seg_driver_pkg::*;
#(
    parameter int LZB     = 1,
    parameter int MAX_VAL = 9999
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score_bin,
    input  logic        score_load,
    input  logic [3:0]  anodes,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        ovf
);

    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [3:0]       CNT_LAST = 4'(DD_SHIFTS - 1);
    localparam int               SH_W     = BCD_W + BIN_W;

    state_t                   state;
    logic [3:0]               cnt;
    logic [SH_W-1:0]          sh;
    logic [SH_W-1:0]          sh_next;
    logic [BCD_W-1:0]         digits;
    logic                     pend_v;
    logic [BIN_W-1:0]         pend_reg;
    logic [BIN_W-1:0]         start_val;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5)
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // Clamp the operand to the displayable ceiling
    function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
        return (v > MAX_BIN) ? MAX_BIN : v;
    endfunction

    // A queued request outranks a fresh one arriving on the same edge
    always_comb begin
        start_val = pend_v ? pend_reg : score_bin;
        sh_next   = dd_step(sh);
    end

    // Conversion FSM, pending slot and committed digit register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh       <= '0;
            digits   <= '0;
            pend_v   <= 1'b0;
            pend_reg <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend_v || score_load) begin
                        ovf   <= (start_val > MAX_BIN);
                        sh    <= {{BCD_W{1'b0}}, sat(start_val)};
                        cnt   <= '0;
                        state <= ST_CONV;
                    end
                    // Draining the slot; a simultaneous load refills it
                    if (pend_v) begin
                        pend_v <= score_load;
                        if (score_load)
                            pend_reg <= score_bin;
                    end
                end
                ST_CONV: begin
                    sh  <= sh_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        digits <= sh_next[SH_W-1:BIN_W];
                        state  <= ST_IDLE;
                    end
                    // Loads during conversion are queued; the latest one wins
                    if (score_load) begin
                        pend_reg <= score_bin;
                        pend_v   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CONV);
    assign dp   = 1'b1;

    logic [3:0] dsel;
    logic       dblank;
    logic       dvalid;
    logic [6:0] dglyph;
    logic       z3, z2, z1;

    // Digit select for the enabled anode, with leading-zero blanking
    always_comb begin
        z3     = (digits[15:12] == 4'd0);
        z2     = z3 && (digits[11:8] == 4'd0);
        z1     = z2 && (digits[7:4] == 4'd0);
        dsel   = digits[3:0];
        dblank = 1'b0;
        dvalid = 1'b1;
        case (anodes)
            AN_D3: begin dsel = digits[15:12]; dblank = (LZB != 0) && z3; end
            AN_D2: begin dsel = digits[11:8];  dblank = (LZB != 0) && z2; end
            AN_D1: begin dsel = digits[7:4];   dblank = (LZB != 0) && z1; end
            AN_D0: begin dsel = digits[3:0];   dblank = 1'b0;             end
            default: dvalid = 1'b0;
        endcase
    end

    seg7_decode u_dec (
        .bcd   (dsel),
        .blank (dblank),
        .seg   (dglyph)
    );

    // Registered segment bus; illegal anode patterns drive all segments off
    always_ff @(posedge clk) begin
        if (rst)
            seg <= SEG_BLANK;
        else
            seg <= dvalid ? dglyph : SEG_BLANK;
    end

endmodule

// File: tb/tb_score_seg_driver.sv
// Directed bench for score_seg_driver with hand-computed glyph expectations.
module tb_score_seg_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] score_bin = '0;
    logic        score_load = 1'b0;
    logic [3:0]  anodes = 4'b1111;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    score_seg_driver #(.LZB(1), .MAX_VAL(9999)) dut (
        .clk        (clk),
        .rst        (rst),
        .score_bin  (score_bin),
        .score_load (score_load),
        .anodes     (anodes),
        .seg        (seg),
        .dp         (dp),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [13:0] v);
        score_bin  = v;
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
    endtask

    task automatic show(input string tag, input logic [3:0] an, input logic [6:0] exp);
        anodes = an;
        tick();
        chk(tag, {25'b0, seg}, {25'b0, exp});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic count_busy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (busy) n++;
        end
    endtask

    initial begin
        int n;

        // 1: reset
        tick(); tick();
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_dp", {31'b0, dp}, 32'd1);
        rst = 1'b0;
        show("rst_units0", 4'b1110, 7'h40);

        // 2: 1234, busy length then each slot
        load(14'd1234);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_len", n, 32'd14);
        show("d3_1", 4'b0111, 7'h79);
        show("d2_2", 4'b1011, 7'h24);
        show("d1_3", 4'b1101, 7'h30);
        show("d0_4", 4'b1110, 7'h19);

        // 3: saturation, then small value with blanking
        load(14'd12000);
        tick(); tick();
        show("atomic_mid", 4'b1110, 7'h19);
        wait_idle("sat_done");
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        show("sat_d3", 4'b0111, 7'h10);
        show("sat_d2", 4'b1011, 7'h10);
        show("sat_d1", 4'b1101, 7'h10);
        show("sat_d0", 4'b1110, 7'h10);
        load(14'd5);
        wait_idle("five_done");
        chk("ovf_clr", {31'b0, ovf}, 32'd0);
        show("lzb_d3", 4'b0111, 7'h7F);
        show("lzb_d2", 4'b1011, 7'h7F);
        show("lzb_d1", 4'b1101, 7'h7F);
        show("lzb_d0", 4'b1110, 7'h12);

        // 4: 42 at E0, 77 at E3, 88 at E9
        load(14'd42);
        tick(); tick();
        load(14'd77);
        for (int i = 0; i < 5; i++) tick();
        load(14'd88);
        for (int i = 0; i < 5; i++) tick();
        chk("e14_idle", {31'b0, busy}, 32'd0);
        show("show42_d0", 4'b1110, 7'h24);
        chk("pend_start", {31'b0, busy}, 32'd1);
        show("show42_d1", 4'b1101, 7'h19);
        wait_idle("p88_done");
        show("show88_d0", 4'b1110, 7'h00);
        show("show88_d1", 4'b1101, 7'h00);
        show("show88_d2", 4'b1011, 7'h7F);
        count_busy(20, n);
        chk("no_third", n, 32'd0);

        // 5: 9999 with a queued load, reset at E7
        load(14'd9999);
        tick(); tick(); tick();
        load(14'd3);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_seg", {25'b0, seg}, 32'h7F);
        chk("abort_ovf", {31'b0, ovf}, 32'd0);
        count_busy(20, n);
        chk("abort_nopend", n, 32'd0);
        show("abort_d0", 4'b1110, 7'h40);
        show("abort_d3", 4'b0111, 7'h7F);

        // 6: illegal anode patterns
        show("an_1111", 4'b1111, 7'h7F);
        show("an_0011", 4'b0011, 7'h7F);
        show("an_0000", 4'b0000, 7'h7F);
        chk("dp_end", {31'b0, dp}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
